// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory pin bundle for mem_access_unit.
// slave is the unit's view; master is the datapath/memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [63:0] mem_address;
  logic [63:0] mem_d_in;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_d_out;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_d_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_d_in, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_d_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_d_in, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a 64-bit byte-addressed memory.
// Narrow stores are read-modify-write; loads return zero/sign-extended data.
module mem_access_unit #(
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  // Highest legal start address; compared in 64 bits so huge addresses never wrap.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_SIZE) - 64'd8;

  state_e      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [63:0] wdata_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [63:0] resp_rdata_q;
  logic [63:0] mem_address_q;
  logic [63:0] mem_d_in_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic [63:0] rdata_d;
  logic [63:0] merged_d;

  function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    case (size)
      2'd0:    return {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    return {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    return {{32{sgn & raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] old,
                                              input logic [63:0] wdata,
                                              input logic [1:0]  size);
    case (size)
      2'd0:    return {old[63:8],  wdata[7:0]};
      2'd1:    return {old[63:16], wdata[15:0]};
      2'd2:    return {old[63:32], wdata[31:0]};
      default: return wdata;
    endcase
  endfunction

  always_comb begin
    rdata_d  = extend_load(bus.mem_d_out, size_q, signed_q);
    merged_d = merge_store(bus.mem_d_out, wdata_q, size_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_d_in_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            wdata_q  <= bus.req_wdata;
            ready_q  <= 1'b0;
            if (bus.req_addr > LAST_ADDR) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!bus.req_write || bus.req_size != 2'd3) begin
              state_q       <= RD;
              mem_read_q    <= 1'b1;
              mem_address_q <= bus.req_addr;
            end else begin
              state_q       <= WR;
              mem_write_q   <= 1'b1;
              mem_address_q <= bus.req_addr;
              mem_d_in_q    <= bus.req_wdata;
            end
          end
        end
        // mem_d_out has settled by the closing edge of the read cycle.
        RD: begin
          if (write_q) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_d_in_q  <= merged_d;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= rdata_d;
          end
        end
        WR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_error  = resp_error_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_d_in    = mem_d_in_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;

endmodule
